// File: rtl/da2_ref_comp.sv
// Dual-channel serial driver for a pair of DAC121S101-style 12-bit DACs.
// Two 16-bit frames {2'b00, PD_MODE, DATA} are shifted out MSB first on D1/D2
// together. nSYNC frames the transfer. CLK_OUT is a free-running CLK/2 clock.
// All frame state changes on "rise ticks", so the DAC sees stable data on
// every CLK_OUT falling edge.
// Optional build macro: DA2_OFFSET_BINARY_EN converts two's-complement samples
// to offset binary at latch time by inverting the sample MSB.
module da2_ref_comp #(
    parameter logic [1:0]  PD_MODE = 2'b00,
    parameter int unsigned DATA_W  = 12
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [DATA_W-1:0] DATA1,
    input  logic [DATA_W-1:0] DATA2,
    output logic              D1,
    output logic              D2,
    output logic              CLK_OUT,
    output logic              nSYNC,
    output logic              DONE
);

    typedef enum logic [1:0] {StIdle, StShift, StSync} state_t;

    state_t      r_state, w_state_d;
    logic [3:0]  r_cnt, w_cnt_d;
    logic [15:0] r_sh1, w_sh1_d;
    logic [15:0] r_sh2, w_sh2_d;
    logic        r_d1, w_d1_d;
    logic        r_d2, w_d2_d;
    logic        r_nsync, w_nsync_d;
    logic        r_done, w_done_d;
    logic        r_clk_out;

    logic              w_rise;
    logic [DATA_W-1:0] w_data1_conv;
    logic [DATA_W-1:0] w_data2_conv;
    logic [15:0]       w_frame1;
    logic [15:0]       w_frame2;

    // Sample coding applied at latch time.
`ifdef DA2_OFFSET_BINARY_EN
    assign w_data1_conv = {~DATA1[DATA_W-1], DATA1[DATA_W-2:0]};
    assign w_data2_conv = {~DATA2[DATA_W-1], DATA2[DATA_W-2:0]};
`else
    assign w_data1_conv = DATA1;
    assign w_data2_conv = DATA2;
`endif

    assign w_frame1 = {2'b00, PD_MODE, w_data1_conv};
    assign w_frame2 = {2'b00, PD_MODE, w_data2_conv};

    // This edge takes CLK_OUT from 0 to 1.
    assign w_rise = ~r_clk_out;

    // Serial clock phase: toggles every CLK cycle once out of reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_clk_out <= 1'b0;
        end else begin
            r_clk_out <= ~r_clk_out;
        end
    end

    // Frame state and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_sh1   <= 16'd0;
            r_sh2   <= 16'd0;
            r_d1    <= 1'b0;
            r_d2    <= 1'b0;
            r_nsync <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_sh1   <= w_sh1_d;
            r_sh2   <= w_sh2_d;
            r_d1    <= w_d1_d;
            r_d2    <= w_d2_d;
            r_nsync <= w_nsync_d;
            r_done  <= w_done_d;
        end
    end

    // Next-state logic; everything except DONE holds between rise ticks.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_sh1_d   = r_sh1;
        w_sh2_d   = r_sh2;
        w_d1_d    = r_d1;
        w_d2_d    = r_d2;
        w_nsync_d = r_nsync;
        w_done_d  = 1'b0;
        if (w_rise) begin
            unique case (r_state)
                StIdle: begin
                    w_nsync_d = 1'b1;
                    w_d1_d    = 1'b0;
                    w_d2_d    = 1'b0;
                    if (START) begin
                        w_sh1_d   = w_frame1;
                        w_sh2_d   = w_frame2;
                        w_d1_d    = w_frame1[15];
                        w_d2_d    = w_frame2[15];
                        w_nsync_d = 1'b0;
                        w_cnt_d   = 4'd15;
                        w_state_d = StShift;
                    end
                end
                StShift: begin
                    if (r_cnt != 4'd0) begin
                        // Shift register keeps the bit to present next at [14].
                        w_cnt_d = r_cnt - 4'd1;
                        w_sh1_d = {r_sh1[14:0], 1'b0};
                        w_sh2_d = {r_sh2[14:0], 1'b0};
                        w_d1_d  = r_sh1[14];
                        w_d2_d  = r_sh2[14];
                    end else begin
                        w_nsync_d = 1'b1;
                        w_d1_d    = 1'b0;
                        w_d2_d    = 1'b0;
                        w_done_d  = 1'b1;
                        w_state_d = StSync;
                    end
                end
                StSync: begin
                    // One extra CLK_OUT period of nSYNC high before re-arming.
                    w_state_d = StIdle;
                end
                default: begin
                    w_state_d = StIdle;
                end
            endcase
        end
    end

    assign CLK_OUT = r_clk_out;
    assign nSYNC   = r_nsync;
    assign D1      = r_d1;
    assign D2      = r_d2;
    assign DONE    = r_done;

endmodule

// File: tb/tb_da2_ref_comp.sv
// Directed self-checking bench for da2_ref_comp.
// Outputs are sampled on CLK falling edges; a bit is captured whenever
// CLK_OUT=1 and nSYNC=0, i.e. the value the DAC takes on the next CLK_OUT fall.
module tb_da2_ref_comp;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [11:0] DATA1;
    logic [11:0] DATA2;
    logic        D1, D2, CLK_OUT, nSYNC, DONE;

    int n_total = 0;
    int n_pass  = 0;

    da2_ref_comp dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .DATA1   (DATA1),
        .DATA2   (DATA2),
        .D1      (D1),
        .D2      (D2),
        .CLK_OUT (CLK_OUT),
        .nSYNC   (nSYNC),
        .DONE    (DONE)
    );

    always #5 CLK = ~CLK;

    // Expected 12-bit payload after the optional coding step.
    function automatic logic [11:0] exp_code(input logic [11:0] x);
`ifdef DA2_OFFSET_BINARY_EN
        return {~x[11], x[10:0]};
`else
        return x;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one frame from IDLE: START for start_len cycles, DATA scrambled mid-frame.
    task automatic do_frame(input logic [11:0] a, input logic [11:0] b, input int start_len,
                            output logic [15:0] c1, output logic [15:0] c2,
                            output int low, output int dones, output int bits);
        c1 = 16'd0; c2 = 16'd0; low = 0; dones = 0; bits = 0;
        @(negedge CLK);
        DATA1 = a;
        DATA2 = b;
        START = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge CLK);
            if (!nSYNC) low++;
            if (DONE) dones++;
            if (CLK_OUT && !nSYNC) begin
                c1 = {c1[14:0], D1};
                c2 = {c2[14:0], D2};
                bits++;
            end
            if (i == start_len - 1) START = 1'b0;
            if (i == 10) begin
                DATA1 = ~a;
                DATA2 = ~b;
            end
        end
    endtask

    initial begin
        logic [15:0] c1, c2;
        int low, dones, bits, bad, tog_bad;
        logic prev_clk_out, prev_ns;
        int nfr, fall_t[4], rise_t[4];
        logic [15:0] fc1[4], fc2[4];

        // Reset then idle.
        RST = 1'b1; START = 1'b0; DATA1 = 12'h0; DATA2 = 12'h0;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        check("rst_nsync", 32'(nSYNC), 32'd1);
        check("rst_d1", 32'(D1), 32'd0);
        check("rst_d2", 32'(D2), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_clk_out", 32'(CLK_OUT), 32'd0);
        RST = 1'b0;
        bad = 0; tog_bad = 0; prev_clk_out = CLK_OUT;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (!nSYNC || D1 || D2 || DONE) bad++;
            if (CLK_OUT === prev_clk_out) tog_bad++;
            prev_clk_out = CLK_OUT;
        end
        check("idle_quiet", 32'(bad), 32'd0);
        check("idle_toggle", 32'(tog_bad), 32'd0);

        // Single frame, START held for 2 CLK.
        do_frame(12'hABC, 12'h123, 2, c1, c2, low, dones, bits);
        check("single_d1", 32'(c1), 32'({4'h0, exp_code(12'hABC)}));
        check("single_d2", 32'(c2), 32'({4'h0, exp_code(12'h123)}));
        check("single_low", 32'(low), 32'd32);
        check("single_done", 32'(dones), 32'd1);
        check("single_bits", 32'(bits), 32'd16);
        check("single_idle", 32'(nSYNC), 32'd1);

        // Boundary data.
        do_frame(12'hFFF, 12'h000, 2, c1, c2, low, dones, bits);
        check("bound_d1", 32'(c1), 32'({4'h0, exp_code(12'hFFF)}));
        check("bound_d2", 32'(c2), 32'({4'h0, exp_code(12'h000)}));
        check("bound_lead", 32'({c1[15:12], c2[15:12]}), 32'd0);

        // Back-to-back with START held high; DATA advanced after each DONE.
        @(negedge CLK);
        DATA1 = 12'h100; DATA2 = 12'h200; START = 1'b1;
        nfr = 0; prev_ns = nSYNC; c1 = 16'd0; c2 = 16'd0;
        for (int i = 0; i < 120; i++) begin
            @(negedge CLK);
            if (prev_ns && !nSYNC && nfr < 4) begin
                fall_t[nfr] = i; c1 = 16'd0; c2 = 16'd0;
            end
            if (CLK_OUT && !nSYNC) begin
                c1 = {c1[14:0], D1};
                c2 = {c2[14:0], D2};
            end
            if (!prev_ns && nSYNC && nfr < 4) begin
                rise_t[nfr] = i; fc1[nfr] = c1; fc2[nfr] = c2; nfr++;
            end
            if (DONE) begin
                DATA1 = DATA1 + 12'h1;
                DATA2 = DATA2 + 12'h1;
            end
            prev_ns = nSYNC;
        end
        START = 1'b0;
        check("b2b_frames", 32'(nfr), 32'd3);
        if (nfr >= 3) begin
            check("b2b_period0", 32'(fall_t[1] - fall_t[0]), 32'd36);
            check("b2b_period1", 32'(fall_t[2] - fall_t[1]), 32'd36);
            check("b2b_gap", 32'(fall_t[1] - rise_t[0]), 32'd4);
            check("b2b_f0", 32'({fc1[0], fc2[0]}),
                  32'({4'h0, exp_code(12'h100), 4'h0, exp_code(12'h200)}));
            check("b2b_f1", 32'({fc1[1], fc2[1]}),
                  32'({4'h0, exp_code(12'h101), 4'h0, exp_code(12'h201)}));
            check("b2b_f2", 32'({fc1[2], fc2[2]}),
                  32'({4'h0, exp_code(12'h102), 4'h0, exp_code(12'h202)}));
        end
        repeat (60) @(negedge CLK);

        // Mid-frame reset after 8 bits.
        DATA1 = 12'h3C3; DATA2 = 12'hC3C; START = 1'b1;
        bits = 0; dones = 0;
        for (int i = 0; i < 60 && bits < 8; i++) begin
            @(negedge CLK);
            if (i == 1) START = 1'b0;
            if (DONE) dones++;
            if (CLK_OUT && !nSYNC) bits++;
        end
        START = 1'b0;
        check("mid_bits", 32'(bits), 32'd8);
        RST = 1'b1;
        @(negedge CLK);
        check("mid_nsync", 32'(nSYNC), 32'd1);
        check("mid_d", 32'({D1, D2}), 32'd0);
        RST = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (DONE) dones++;
        end
        check("mid_nodone", 32'(dones), 32'd0);
        do_frame(12'h5A5, 12'hA5A, 2, c1, c2, low, dones, bits);
        check("mid_after_d1", 32'(c1), 32'({4'h0, exp_code(12'h5A5)}));
        check("mid_after_d2", 32'(c2), 32'({4'h0, exp_code(12'hA5A)}));
        check("mid_after_low", 32'(low), 32'd32);

        // Sample coding corners.
        do_frame(12'h800, 12'h7FF, 2, c1, c2, low, dones, bits);
`ifdef DA2_OFFSET_BINARY_EN
        check("code_800", 32'(c1), 32'h0000_0000);
        check("code_7ff", 32'(c2), 32'h0000_0FFF);
`else
        check("code_800", 32'(c1), 32'h0000_0800);
        check("code_7ff", 32'(c2), 32'h0000_07FF);
`endif
        do_frame(12'h000, 12'h001, 2, c1, c2, low, dones, bits);
`ifdef DA2_OFFSET_BINARY_EN
        check("code_000", 32'(c1), 32'h0000_0800);
`else
        check("code_000", 32'(c1), 32'h0000_0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
